// File: rtl/fp_round_pack.sv
// ============================================================================
// fp_round_pack
// ----------------------------------------------------------------------------
// Rounding and packing stage of the single-precision FP adder/multiplier.
// Takes a normalized sign, biased exponent and 27-bit extended mantissa
// {hidden, frac[22:0], guard, round, sticky}. It rounds to 23 fraction bits
// and re-normalizes when rounding carries out of the hidden bit. Exponent
// overflow saturates to infinity. The result is presented as a packed
// IEEE-754 binary32 word.
//
// The stage handles one operation at a time, using a valid/ready handshake
// on both sides.
//
// Build option:
//   FP_ROUND_RNE_EN  defined   -> round to nearest, ties to even
//                    undefined -> truncation (round toward zero)
//
// Ports:
//   clk        in   1   clock, all state updates on posedge
//   reset      in   1   synchronous, active-low
//   in_valid   in   1   upstream presents an operand
//   in_ready   out  1   stage can accept (high only while idle)
//   in_sign    in   1   result sign
//   in_exp     in   8   biased exponent after normalization
//   in_mant    in   27  {hidden, frac[22:0], guard, round, sticky}
//   out_valid  out  1   packed result is held for the consumer
//   out_ready  in   1   consumer takes the result
//   result     out  32  {sign, exp[7:0], frac[22:0]}
//   overflow   out  1   exponent saturated, result is +/- infinity
//   inexact    out  1   any of guard/round/sticky was set
// ============================================================================
module fp_round_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        inexact
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROUND  = 3'd1,
        RENORM = 3'd2,
        PACK   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t      state;
    logic        sign_r;
    logic [8:0]  exp_r;
    logic [26:0] mant_r;
    logic [22:0] frac_r;
    logic        round_up;
    logic [24:0] mant_sum;

    // Rounding decision from the captured mantissa. Round-to-nearest-even
    // increments when guard is set and the value is above the halfway point
    // (round or sticky set), or sits exactly on it with an odd LSB.
    // Truncation never increments.
`ifdef FP_ROUND_RNE_EN
    assign round_up = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
`else
    assign round_up = 1'b0;
`endif

    // The sum is {carry, hidden, frac}. Bit 24 is set only when an all-ones
    // significand rounds up, and that case needs a one-place
    // re-normalization.
    assign mant_sum = {1'b0, mant_r[26:3]} + {24'h0, round_up};

    // Main control FSM. All outputs are registered here, so in_ready and
    // out_valid change only on clock edges.
    //
    // The exponent is held in 9 bits so that the increment 0xFE -> 0xFF
    // (and 0xFF -> 0x100) in RENORM stays visible to the saturation
    // compare in PACK.
    //
    // A zero or denormal exponent clears the captured mantissa. This flushes
    // the result to signed zero and also clears the inexact bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            exp_r     <= 9'h0;
            mant_r    <= 27'h0;
            frac_r    <= 23'h0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= 32'h0;
            overflow  <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_r   <= in_sign;
                        exp_r    <= {1'b0, in_exp};
                        if (in_exp == 8'h00) begin
                            mant_r <= 27'h0;
                        end else begin
                            mant_r <= in_mant;
                        end
                        in_ready <= 1'b0;
                        state    <= ROUND;
                    end
                end

                ROUND: begin
                    frac_r <= mant_sum[22:0];
                    if (mant_sum[24]) begin
                        state <= RENORM;
                    end else begin
                        state <= PACK;
                    end
                end

                RENORM: begin
                    frac_r <= 23'h0;
                    exp_r  <= exp_r + 9'd1;
                    state  <= PACK;
                end

                PACK: begin
                    if (exp_r >= 9'h0FF) begin
                        result   <= {sign_r, 8'hFF, 23'h0};
                        overflow <= 1'b1;
                    end else begin
                        result   <= {sign_r, exp_r[7:0], frac_r};
                        overflow <= 1'b0;
                    end
                    inexact   <= |mant_r[2:0];
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end

                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// ============================================================================
// tb_fp_round_pack
// ----------------------------------------------------------------------------
// Directed testbench for fp_round_pack. Each scenario task drives its own
// vectors and compares against hand-computed constants. Expectations that
// depend on the rounding mode follow the FP_ROUND_RNE_EN define.
//
// Latency is counted in clock edges. The accept edge is edge 1, and the
// count ends at the edge after which out_valid reads high.
// ============================================================================
module tb_fp_round_pack;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        inexact;

    int checks;
    int errors;

    fp_round_pack dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .inexact   (inexact)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand and waits for out_valid. Inputs change and
    // outputs are sampled 1 unit after each rising edge. lat returns 99 if
    // in_ready or out_valid never arrives.
    task automatic start_op(input logic s, input logic [7:0] e,
                            input logic [22:0] f, input logic [2:0] grs,
                            output int lat);
        int wait_cnt;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        in_sign  = s;
        in_exp   = e;
        in_mant  = {(e != 8'h00), f, grs};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    // One-cycle out_ready pulse that retires the held result.
    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h00;
        in_mant   = 27'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
            overflow !== 1'b0 || inexact !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b result=%h ov=%b ix=%b, expected 1 0 00000000 0 0",
                     in_ready, out_valid, result, overflow, inexact);
        end
    endtask

    task automatic test_exact();
        int lat;
        start_op(1'b0, 8'h82, 23'h0C0080, 3'b000, lat);
        checks++;
        if (result !== 32'h410C0080 || overflow !== 1'b0 || inexact !== 1'b0) begin
            errors++;
            $display("[TB] FAIL exact: result=%h ov=%b ix=%b, expected 410c0080 0 0", result, overflow, inexact);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL exact_latency: got %0d, expected 3", lat);
        end
        release_op();
    endtask

    task automatic test_tie_even();
        int lat;
        logic [31:0] exp_odd;
`ifdef FP_ROUND_RNE_EN
        exp_odd = 32'h3F800002;
`else
        exp_odd = 32'h3F800001;
`endif
        start_op(1'b0, 8'h7F, 23'h000001, 3'b100, lat);
        checks++;
        if (result !== exp_odd || inexact !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tie_odd: result=%h ix=%b ov=%b, expected %h 1 0", result, inexact, overflow, exp_odd);
        end
        release_op();
        start_op(1'b0, 8'h7F, 23'h000000, 3'b100, lat);
        checks++;
        if (result !== 32'h3F800000 || inexact !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tie_even: result=%h ix=%b, expected 3f800000 1", result, inexact);
        end
        release_op();
    endtask

    task automatic test_round_carry();
        int lat;
        logic [31:0] exp_res;
        int exp_lat;
`ifdef FP_ROUND_RNE_EN
        exp_res = 32'h40000000;
        exp_lat = 4;
`else
        exp_res = 32'h3FFFFFFF;
        exp_lat = 3;
`endif
        start_op(1'b0, 8'h7F, 23'h7FFFFF, 3'b110, lat);
        checks++;
        if (result !== exp_res || inexact !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL round_carry: result=%h ix=%b ov=%b, expected %h 1 0", result, inexact, overflow, exp_res);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("[TB] FAIL round_carry_latency: got %0d, expected %0d", lat, exp_lat);
        end
        release_op();
    endtask

    task automatic test_overflow();
        int lat;
        logic [31:0] exp_res;
        logic        exp_ov;
`ifdef FP_ROUND_RNE_EN
        exp_res = 32'hFF800000;
        exp_ov  = 1'b1;
`else
        exp_res = 32'hFF7FFFFF;
        exp_ov  = 1'b0;
`endif
        start_op(1'b1, 8'hFE, 23'h7FFFFF, 3'b111, lat);
        checks++;
        if (result !== exp_res || overflow !== exp_ov || inexact !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_round: result=%h ov=%b ix=%b, expected %h %b 1", result, overflow, inexact, exp_res, exp_ov);
        end
        release_op();
        start_op(1'b0, 8'hFF, 23'h000000, 3'b000, lat);
        checks++;
        if (result !== 32'h7F800000 || overflow !== 1'b1 || inexact !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_exp_ff: result=%h ov=%b ix=%b, expected 7f800000 1 0", result, overflow, inexact);
        end
        release_op();
    endtask

    task automatic test_zero_flush();
        int lat;
        in_sign  = 1'b1;
        in_exp   = 8'h00;
        in_mant  = 27'h5A5A5A7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (result !== 32'h80000000 || overflow !== 1'b0 || inexact !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_flush: result=%h ov=%b ix=%b, expected 80000000 0 0", result, overflow, inexact);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL zero_flush_latency: got %0d, expected 3", lat);
        end
        release_op();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(1'b0, 8'h82, 23'h0C0080, 3'b000, lat);
        in_sign  = 1'b1;
        in_exp   = 8'h90;
        in_mant  = {1'b1, 23'h123456, 3'b101};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (result !== 32'h410C0080 || out_valid !== 1'b1 || in_ready !== 1'b0 || inexact !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: result=%h ov=%b rdy=%b ix=%b, expected 410c0080 1 0 0",
                         i, result, out_valid, in_ready, inexact);
            end
        end
        in_valid = 1'b0;
        release_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(1'b1, 8'h81, 23'h400000, 3'b000, lat);
        checks++;
        if (result !== 32'hC0C00000 || lat !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_first: result=%h lat=%0d, expected c0c00000 3", result, lat);
        end
        release_op();
        start_op(1'b0, 8'h7E, 23'h000000, 3'b001, lat);
        checks++;
        if (result !== 32'h3F000000 || inexact !== 1'b1 || lat !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_second: result=%h ix=%b lat=%0d, expected 3f000000 1 3", result, inexact, lat);
        end
        release_op();
    endtask

    task automatic test_reset_midop();
        in_sign  = 1'b0;
        in_exp   = 8'h85;
        in_mant  = {1'b1, 23'h0000FF, 3'b010};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 ||
            overflow !== 1'b0 || inexact !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midop: out_valid=%b in_ready=%b result=%h ov=%b ix=%b, expected 0 1 00000000 0 0",
                     out_valid, in_ready, result, overflow, inexact);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_partial: out_valid=%b, expected 0", out_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exact();
        test_tie_even();
        test_round_carry();
        test_overflow();
        test_zero_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
